logic_gate_unit: RTL

//  Parametrised, registered N-input bitwise gate unit. It replaces the fixed 2-input single-function gates.

---
 rtl/logic_gate_pkg.sv | 22 ++
 rtl/logic_gate_unit_gate_reduce.sv | 48 ++++
 rtl/logic_gate_unit.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/logic_gate_pkg.sv
// Shared op codes, op type and sweep FSM encoding for the logic gate unit.
package logic_gate_pkg;

    typedef logic [2:0] op_t;

    localparam op_t OP_AND  = 3'd0;
    localparam op_t OP_OR   = 3'd1;
    localparam op_t OP_NAND = 3'd2;
    localparam op_t OP_NOR  = 3'd3;
    localparam op_t OP_XOR  = 3'd4;
    localparam op_t OP_XNOR = 3'd5;
    localparam op_t OP_NOT  = 3'd6;
    localparam op_t OP_BUF  = 3'd7;

    typedef enum logic [1:0] {
        SW_IDLE  = 2'd0,
        SW_DRAIN = 2'd1,
        SW_RUN   = 2'd2,
        SW_DONE  = 2'd3
    } sweep_state_t;

endpackage

// File: rtl/logic_gate_unit_gate_reduce.sv
// Combinational N-operand bitwise reduction; selects one of eight gate functions per lane.
module gate_reduce
    import logic_gate_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 2
) (
    input  logic [NUM_IN*WIDTH-1:0] operands,
    input  op_t                     op,
    output logic [WIDTH-1:0]        result
);

    logic [WIDTH-1:0] and_r;
    logic [WIDTH-1:0] or_r;
    logic [WIDTH-1:0] xor_r;
    logic [WIDTH-1:0] op0;

    assign op0 = operands[WIDTH-1:0];

    // With a single operand the three reductions all collapse to op0, which
    // gives the buffer/invert behaviour of the 2-input ops for free.
    always_comb begin
        and_r = '1;
        or_r  = '0;
        xor_r = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            and_r = and_r & operands[i*WIDTH +: WIDTH];
            or_r  = or_r  | operands[i*WIDTH +: WIDTH];
            xor_r = xor_r ^ operands[i*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        result = op0;
        case (op)
            OP_AND:  result = and_r;
            OP_OR:   result = or_r;
            OP_NAND: result = ~and_r;
            OP_NOR:  result = ~or_r;
            OP_XOR:  result = xor_r;
            OP_XNOR: result = ~xor_r;
            OP_NOT:  result = ~op0;
            OP_BUF:  result = op0;
            default: result = op0;
        endcase
    end

endmodule

// File: rtl/logic_gate_unit.sv
// Registered N-input bitwise gate with valid/ready 2-stage pipeline and a
// truth-table sweep FSM that characterises one op over all input combinations.
module logic_gate_unit
    import logic_gate_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  op_t                     in_op,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    input  logic                    sweep_start,
    input  op_t                     sweep_op,
    output logic                    sweep_busy,
    output logic                    sweep_done,
    output logic [2**NUM_IN-1:0]    truth_table
);

    localparam int TT_W = 2**NUM_IN;

    logic                    rdy_en;
    logic                    vld_p1;
    logic                    vld_p2;
    logic [NUM_IN*WIDTH-1:0] data_p1;
    op_t                     op_p1;
    logic [WIDTH-1:0]        result_p1;
    logic [WIDTH-1:0]        data_p2;
    logic                    s1_ready;
    logic                    s2_ready;
    logic                    accept;

    sweep_state_t            state;
    sweep_state_t            state_nxt;
    op_t                     sweep_op_q;
    logic [NUM_IN-1:0]       cnt;
    logic                    sweep_res;
    logic [TT_W-1:0]         tt;

    assign s2_ready = !vld_p2 || out_ready;
    assign s1_ready = !vld_p1 || s2_ready;
    assign accept   = in_valid && in_ready;

    // rdy_en keeps in_ready low through reset and rises one edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            if (s1_ready)
                vld_p1 <= accept;
        end
    end

    // ---- stage 1: operand/op capture ----
    always_ff @(posedge clk) begin
        if (accept) begin
            data_p1 <= in_data;
            op_p1   <= in_op;
        end
    end

    gate_reduce #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN)
    ) u_dp_gate (
        .operands (data_p1),
        .op       (op_p1),
        .result   (result_p1)
    );

    // ---- stage 2: result register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2  <= 1'b0;
            data_p2 <= '0;
        end else if (s2_ready) begin
            vld_p2 <= vld_p1;
            if (vld_p1)
                data_p2 <= result_p1;
        end
    end

    // Sweep lane: operand i is the single bit cnt[i].
    gate_reduce #(
        .WIDTH  (1),
        .NUM_IN (NUM_IN)
    ) u_sweep_gate (
        .operands (cnt),
        .op       (sweep_op_q),
        .result   (sweep_res)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= SW_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SW_IDLE:  if (sweep_start) state_nxt = SW_DRAIN;
            SW_DRAIN: if (!vld_p1 && !vld_p2) state_nxt = SW_RUN;
            SW_RUN:   if (cnt == {NUM_IN{1'b1}}) state_nxt = SW_DONE;
            SW_DONE:  state_nxt = SW_IDLE;
            default:  state_nxt = SW_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (state == SW_IDLE && sweep_start)
            sweep_op_q <= sweep_op;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            tt  <= '0;
        end else begin
            if (state == SW_IDLE && sweep_start)
                tt <= '0;
            if (state == SW_DRAIN)
                cnt <= '0;
            if (state == SW_RUN) begin
                tt[cnt] <= sweep_res;
                cnt     <= cnt + 1'b1;
            end
        end
    end

    always_comb begin
        in_ready    = rdy_en && s1_ready && (state == SW_IDLE);
        sweep_busy  = (state != SW_IDLE);
        sweep_done  = (state == SW_DONE);
        out_valid   = vld_p2;
        out_data    = data_p2;
        truth_table = tt;
    end

endmodule
